// File: rtl/hazard_flush_ctrl.sv
// Hazard, flush and forwarding controller for the 5-stage core: load-use bubbles,
// branch flushes, data-memory wait holds with a sticky timeout. Optional macro HAZARD_PERF_CNT_EN.
module hazard_flush_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ifid_instr,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  idex_rs1,
    input  logic [4:0]  idex_rs2,
    input  logic        br_taken,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_memacc,
    input  logic        dmem_ready,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pipe_hold,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        err_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN,
        S_LOAD_STALL,
        S_MEM_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WCNT_W-1:0]   wait_inc;
    logic                err_q, err_d;

    logic [4:0] ifid_rs1;
    logic [4:0] ifid_rs2;
    logic       load_use;
    logic       mem_busy;
    logic       unused_instr_bits;

    assign ifid_rs1 = ifid_instr[19:15];
    assign ifid_rs2 = ifid_instr[24:20];
    assign unused_instr_bits = ^{ifid_instr[31:25], ifid_instr[14:0]};

    assign load_use = idex_memread && (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    assign mem_busy = exmem_memacc && !dmem_ready;
    assign wait_inc = (wait_cnt_q == WCNT_MAX) ? WCNT_MAX : wait_cnt_q + 1'b1;

    // EX/MEM has priority over MEM/WB; x0 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       em_we,
        input logic [4:0] em_rd,
        input logic       mw_we,
        input logic [4:0] mw_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (em_we && (em_rd != 5'd0) && (em_rd == rs)) begin
            sel = 2'b10;
        end else if (mw_we && (mw_rd != 5'd0) && (mw_rd == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_hold  = 1'b0;
        fwd_a      = 2'b00;
        fwd_b      = 2'b00;

        if (!reset) begin
            fwd_a = fwd_sel(idex_rs1, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
            fwd_b = fwd_sel(idex_rs2, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);

            case (state_q)
                S_RUN: begin
                    if (mem_busy) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        pipe_hold  = 1'b1;
                        state_d    = S_MEM_WAIT;
                        wait_cnt_d = WCNT_W'(1);
                    end else if (br_taken) begin
                        // The redirect squashes the younger instruction, so any load-use is moot.
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                        state_d    = S_LOAD_STALL;
                    end
                end

                S_LOAD_STALL: begin
                    ifid_flush = br_taken;
                    idex_flush = br_taken;
                    state_d    = S_RUN;
                end

                S_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_d    = S_RUN;
                        wait_cnt_d = '0;
                    end else begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        pipe_hold  = 1'b1;
                        wait_cnt_d = wait_inc;
                        if (wait_inc == WCNT_MAX) begin
                            err_d = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    assign err_timeout = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (ifid_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`endif

endmodule
